rv32m_muldiv_ctrl: RTL and testbench

//  Iterative RV32M multiply/divide unit for the EX stage. It runs beside the single-cycle ALU.
//  It accepts one M-extension op from EX and sequences a shift-add multiply or restoring divide over XLEN cycles.
//  It stalls the pipeline until the result is ready.
//  The decoder routes opcode OP with funct7=0000001 here instead of to the ALU control path.

---
 rtl/rv32m_muldiv_ctrl_pkg.sv | 37 +++
 rtl/rv32m_muldiv_ctrl_if.sv | 26 ++
 rtl/muldiv_iter_core.sv | 52 +++++
 rtl/rv32m_muldiv_ctrl.sv | 121 ++++++++++++
 tb/tb_rv32m_muldiv_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32m_muldiv_ctrl_pkg.sv
// RV32M multiply/divide unit: shared types and constants.
// Imported by the interface, the datapath core and the control top.
package rv32m_muldiv_ctrl_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic signed_a(input logic [2:0] f3);
        return (f3 != F3_MULHU) && (f3 != F3_DIVU) && (f3 != F3_REMU);
    endfunction

    function automatic logic signed_b(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/rv32m_muldiv_ctrl_if.sv
// EX-stage <-> M-unit bundle.
// master = EX stage, slave = muldiv unit.
interface rv32m_muldiv_ctrl_if;
    import rv32m_muldiv_ctrl_pkg::*;

    logic            flush_i;
    logic            valid_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output flush_i, valid_i, funct3_i, op_a_i, op_b_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  flush_i, valid_i, funct3_i, op_a_i, op_b_i,
        output stall_o, busy_o, done_o, result_o
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// Iterative shift-add multiply / restoring divide datapath.
// Operates on magnitudes only; one iteration per step, no control state.
module muldiv_iter_core
    import rv32m_muldiv_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_in,
    input  logic [XLEN-1:0]   b_in,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   m_q;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rsh;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] mul_nx;
    logic [2*XLEN-1:0] div_nx;

    // Next accumulator for one multiply step and one divide step
    always_comb begin
        sum    = {1'b0, acc_q[2*XLEN-1:XLEN]}
               + (acc_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
        mul_nx = {sum, acc_q[XLEN-1:1]};
        rsh    = acc_q[2*XLEN-1:XLEN-1];
        diff   = rsh - {1'b0, m_q};
        if (!diff[XLEN])
            div_nx = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_nx = {rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    // Accumulator and multiplicand/divisor registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            m_q   <= '0;
        end else if (load) begin
            acc_q <= {{XLEN{1'b0}}, a_in};
            m_q   <= b_in;
        end else if (step) begin
            acc_q <= is_div ? div_nx : mul_nx;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/rv32m_muldiv_ctrl.sv
// RV32M iterative multiply/divide controller for the EX stage.
// Owns FSM, counter, sign fix-up, special cases and stall/done.
module rv32m_muldiv_ctrl
    import rv32m_muldiv_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    rv32m_muldiv_ctrl_if.slave io
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic              sa_q, sb_q;
    logic [XLEN-1:0]   res_q;

    logic              accept;
    logic              in_sa, in_sb;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   spec_res;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_res;
    logic              core_load, core_step;

    // Operand decode: sign flags, magnitudes and RISC-V special cases
    always_comb begin
        in_sa    = signed_a(io.funct3_i) & io.op_a_i[XLEN-1];
        in_sb    = signed_b(io.funct3_i) & io.op_b_i[XLEN-1];
        mag_a    = in_sa ? -io.op_a_i : io.op_a_i;
        mag_b    = in_sb ? -io.op_b_i : io.op_b_i;
        div_zero = io.funct3_i[2] & (io.op_b_i == '0);
        div_ovf  = io.funct3_i[2] & ~io.funct3_i[0]
                 & (io.op_a_i == XMIN) & (io.op_b_i == '1);
        special  = div_zero | div_ovf;
        spec_res = '0;
        unique case (1'b1)
            div_zero: spec_res = io.funct3_i[1] ? io.op_a_i : '1;
            div_ovf:  spec_res = io.funct3_i[1] ? '0 : XMIN;
            default:  spec_res = '0;
        endcase
    end

    assign accept = (state_q == S_IDLE) & io.valid_i & ~io.flush_i;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: begin
                if (io.flush_i)
                    state_d = S_IDLE;
                else if (cnt_q == CNT_W'(XLEN-1))
                    state_d = S_FIX;
            end
            S_FIX:  state_d = io.flush_i ? S_IDLE : S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign core_load = accept & ~special;
    assign core_step = (state_q == S_CALC);

    muldiv_iter_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (core_load),
        .step   (core_step),
        .is_div (f3_q[2]),
        .a_in   (mag_a),
        .b_in   (mag_b),
        .acc_o  (acc)
    );

    // Sign fix-up and result word selection
    always_comb begin
        prod = (sa_q ^ sb_q) ? -acc : acc;
        quo  = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (!f3_q[2])
            fix_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                           : prod[2*XLEN-1:XLEN];
        else
            fix_res = f3_q[1] ? rem : quo;
    end

    // State, counter, latched op info and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
                f3_q  <= io.funct3_i;
                sa_q  <= in_sa;
                sb_q  <= in_sb;
            end else if (state_q == S_CALC) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept & special)
                res_q <= spec_res;
            else if ((state_q == S_FIX) & ~io.flush_i)
                res_q <= fix_res;
        end
    end

    assign io.stall_o  = accept | (state_q == S_CALC) | (state_q == S_FIX);
    assign io.busy_o   = (state_q == S_CALC) | (state_q == S_FIX);
    assign io.done_o   = (state_q == S_DONE) & ~io.flush_i;
    assign io.result_o = res_q;

endmodule

// File: tb/tb_rv32m_muldiv_ctrl.sv
// Scoreboard bench for rv32m_muldiv_ctrl.
// Directed vectors plus randomized ops against an arithmetic model.
module tb_rv32m_muldiv_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sbq[$];

    rv32m_muldiv_ctrl_if bus ();

    rv32m_muldiv_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit is_special(input logic [2:0] f3,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        if (f3 < 3'd4) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return (f3 == 3'd4 || f3 == 3'd6) &&
               a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] f3,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      xs, ys, ps;
        logic [63:0] pu;
        int          sa, sb;
        xs = longint'($signed(a));
        ys = longint'($signed(b));
        sa = int'(a);
        sb = int'(b);
        case (f3)
            3'd0: begin ps = xs * ys; return ps[31:0]; end
            3'd1: begin ps = xs * ys; return ps[63:32]; end
            3'd2: begin ps = xs * longint'({32'd0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every done_o pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.done_o) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done act=1 exp=0 t=%0t", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", bus.result_o, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called aligned just after a posedge; returns aligned after op's DONE
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int   k;
        int   lat;
        exp_t e;
        bus.valid_i  = 1'b1;
        bus.funct3_i = f3;
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        k   = cyc;
        lat = is_special(f3, a, b) ? 1 : 34;
        e.res = exp;
        e.due = k + lat;
        sbq.push_back(e);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            chk("stall", {31'd0, bus.stall_o}, {31'd0, i < lat});
            chk("busy", {31'd0, bus.busy_o}, {31'd0, (i > 0) && (i < lat)});
            @(posedge clk);
            #1;
            bus.valid_i = 1'b0;
        end
    endtask

    initial begin
        bus.flush_i  = 1'b0;
        bus.valid_i  = 1'b0;
        bus.funct3_i = 3'd0;
        bus.op_a_i   = 32'd0;
        bus.op_b_i   = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_done", {31'd0, bus.done_o}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd7, 32'd2, 32'd3);
        run_op(3'd7, 32'd7, 32'd2, 32'd1);
        run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op(3'd6, 32'd5, 32'd0, 32'd5);
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Flush at CALC counter=10, then re-accept two cycles later
        bus.valid_i  = 1'b1;
        bus.funct3_i = 3'd0;
        bus.op_a_i   = 32'd100;
        bus.op_b_i   = 32'd200;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        chk("flush_calc_stall", {31'd0, bus.stall_o}, 32'd1);
        chk("flush_calc_done", {31'd0, bus.done_o}, 32'd0);
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("flush_idle_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("flush_idle_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("flush_idle_done", {31'd0, bus.done_o}, 32'd0);
        @(posedge clk);
        #1;
        run_op(3'd0, 32'd3, 32'd4, 32'd12);

        // valid_i with flush_i in IDLE must not accept
        bus.valid_i  = 1'b1;
        bus.flush_i  = 1'b1;
        bus.funct3_i = 3'd0;
        bus.op_a_i   = 32'd5;
        bus.op_b_i   = 32'd5;
        @(negedge clk);
        chk("vf_stall", {31'd0, bus.stall_o}, 32'd0);
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("vf_busy", {31'd0, bus.busy_o}, 32'd0);
            chk("vf_stall_after", {31'd0, bus.stall_o}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Reset mid-CALC clears outputs immediately
        bus.valid_i  = 1'b1;
        bus.funct3_i = 3'd0;
        bus.op_a_i   = 32'd9;
        bus.op_b_i   = 32'd9;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, bus.busy_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done_o}, 32'd0);
        chk("mid_rst_result", bus.result_o, 32'd0);
        chk("mid_rst_stall", {31'd0, bus.stall_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_busy", {31'd0, bus.busy_o}, 32'd0);
            chk("post_rst_stall", {31'd0, bus.stall_o}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Back-to-back DIVU: second accepted the cycle after DONE
        run_op(3'd5, 32'd100, 32'd7, 32'd14);
        run_op(3'd5, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);

        // Randomized ops against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 15));
                4: b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(f3, a, b, ref_res(f3, a, b));
        end

        for (int w = 0; w < 50 && sbq.size() != 0; w++) @(posedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
